alarm_ring_controller: RTL and testbench

Downstream consumer of the alarm clock's `alarm_triggered` match signal. It turns the level-type time-match into a ring session with an audible beep pattern, snooze handling, a stop button and an auto-timeout. It drives the buzzer pin and the ringing/snoozed status indicators.

---
 rtl/alarm_pkg.sv | 20 ++
 rtl/alarm_ring_controller_beep_gen.sv | 42 ++++
 rtl/alarm_ring_controller.sv | 140 ++++++++++++++
 tb/tb_alarm_ring_controller.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared types and defaults for the alarm ring controller
// Purpose: ring-session state enum, minute-count type and default parameter values.
// Ports: none (package).
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZED = 2'd2,
    ST_LATCHED = 2'd3
  } ring_state_t;

  typedef logic [5:0] min_cnt_t;

  localparam int DEF_BEEP_HALF        = 500;
  localparam int DEF_SNOOZE_MIN       = 9;
  localparam int DEF_RING_TIMEOUT_MIN = 5;
  localparam int DEF_MAX_SNOOZE       = 3;

endpackage

// File: rtl/alarm_ring_controller_beep_gen.sv
// rtl/alarm_ring_controller_beep_gen.sv - buzzer square-wave generator
// Purpose: half-period counter plus toggle flop; output is registered and low when disabled.
// Ports: clk, rst (async, active high), en (pattern enable), restart (start a new
//        pattern high), beep (registered waveform).
module beep_gen #(
  parameter int BEEP_HALF = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic beep
);

  // Keep at least one counter bit so BEEP_HALF = 1 still elaborates.
  localparam int CW = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(BEEP_HALF - 1);

  logic [CW-1:0] r_cnt;
  logic          r_beep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_beep <= 1'b0;
    end else if (!en) begin
      r_cnt  <= '0;
      r_beep <= 1'b0;
    end else if (restart) begin
      r_cnt  <= '0;
      r_beep <= 1'b1;
    end else if (r_cnt == LAST) begin
      r_cnt  <= '0;
      r_beep <= ~r_beep;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  assign beep = r_beep;

endmodule

// File: rtl/alarm_ring_controller.sv
// rtl/alarm_ring_controller.sv - alarm ring session FSM with snooze, stop and timeout
// Purpose: turns the level alarm_triggered match into a ring session with beep
//          pattern, snooze, stop and auto-timeout; all outputs registered.
// Ports: clk, rst (async, active high), min_tick, alarm_triggered, alarm_on,
//        snooze, stop (inputs); buzzer, ringing, snoozed, snooze_count[2:0] (outputs).
module alarm_ring_controller
  import alarm_pkg::*;
#(
  parameter int BEEP_HALF        = DEF_BEEP_HALF,
  parameter int SNOOZE_MIN       = DEF_SNOOZE_MIN,
  parameter int RING_TIMEOUT_MIN = DEF_RING_TIMEOUT_MIN,
  parameter int MAX_SNOOZE       = DEF_MAX_SNOOZE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       min_tick,
  input  logic       alarm_triggered,
  input  logic       alarm_on,
  input  logic       snooze,
  input  logic       stop,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozed,
  output logic [2:0] snooze_count
);

  localparam min_cnt_t   TIMEOUT  = min_cnt_t'(RING_TIMEOUT_MIN);
  localparam min_cnt_t   SNZ_LOAD = min_cnt_t'(SNOOZE_MIN);
  localparam logic [2:0] SNZ_MAX  = 3'(MAX_SNOOZE);

  ring_state_t r_state;
  ring_state_t w_next;
  logic        r_trig_q;
  logic        r_ringing;
  logic        r_snoozed;
  min_cnt_t    r_ring_min;
  min_cnt_t    r_snz_min;
  logic [2:0]  r_snooze_count;

  logic w_trig_evt;
  logic w_timeout;
  logic w_snz_ok;
  logic w_snz_expire;
  logic w_enter_ring;
  logic w_ringing_d;
  logic w_snoozed_d;
  logic w_beep;

  assign w_trig_evt   = alarm_triggered & ~r_trig_q & alarm_on;
  // This tick brings ring_min up to the timeout value.
  assign w_timeout    = min_tick && (r_ring_min >= (TIMEOUT - 1'b1));
  assign w_snz_ok     = snooze && (r_snooze_count < SNZ_MAX);
  // This tick brings snz_min down to zero.
  assign w_snz_expire = min_tick && (r_snz_min <= min_cnt_t'(1));

  // State register plus registered status flags. trig_q resets high so the
  // forced 00:00 match after upstream reset is not seen as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_trig_q  <= 1'b1;
      r_ringing <= 1'b0;
      r_snoozed <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_trig_q  <= alarm_triggered;
      r_ringing <= w_ringing_d;
      r_snoozed <= w_snoozed_d;
    end
  end

  always_comb begin
    w_next = r_state;
    if (!alarm_on) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (w_trig_evt) w_next = ST_RINGING;
        ST_RINGING: begin
          if (stop)           w_next = ST_LATCHED;
          else if (w_snz_ok)  w_next = ST_SNOOZED;
          else if (w_timeout) w_next = ST_LATCHED;
        end
        ST_SNOOZED: begin
          if (stop)              w_next = ST_LATCHED;
          else if (w_snz_expire) w_next = ST_RINGING;
        end
        ST_LATCHED: if (!alarm_triggered) w_next = ST_IDLE;
        default:    w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ringing_d  = (w_next == ST_RINGING);
    w_snoozed_d  = (w_next == ST_SNOOZED);
    w_enter_ring = (w_next == ST_RINGING) && (r_state != ST_RINGING);
  end

  // Session counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snooze_count <= '0;
      r_ring_min     <= '0;
      r_snz_min      <= '0;
    end else begin
      if (r_state == ST_IDLE && w_next == ST_RINGING)
        r_snooze_count <= '0;
      else if (r_state == ST_RINGING && w_next == ST_SNOOZED)
        r_snooze_count <= r_snooze_count + 1'b1;

      if (w_enter_ring)
        r_ring_min <= '0;
      else if (r_state == ST_RINGING && min_tick && r_ring_min < TIMEOUT)
        r_ring_min <= r_ring_min + 1'b1;

      if (r_state == ST_RINGING && w_next == ST_SNOOZED)
        r_snz_min <= SNZ_LOAD;
      else if (r_state == ST_SNOOZED && (w_next == ST_SNOOZED || w_next == ST_RINGING)
               && min_tick && r_snz_min != '0)
        r_snz_min <= r_snz_min - 1'b1;
    end
  end

  beep_gen #(
    .BEEP_HALF(BEEP_HALF)
  ) u_beep (
    .clk    (clk),
    .rst    (rst),
    .en     (w_ringing_d),
    .restart(w_enter_ring),
    .beep   (w_beep)
  );

  assign buzzer       = w_beep;
  assign ringing      = r_ringing;
  assign snoozed      = r_snoozed;
  assign snooze_count = r_snooze_count;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// tb/tb_alarm_ring_controller.sv - directed table-driven bench for alarm_ring_controller
module tb_alarm_ring_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       min_tick = 1'b0;
  logic       alarm_triggered = 1'b1;
  logic       alarm_on = 1'b1;
  logic       snooze = 1'b0;
  logic       stop = 1'b0;
  logic       buzzer;
  logic       ringing;
  logic       snoozed;
  logic [2:0] snooze_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alarm_ring_controller #(
    .BEEP_HALF(4),
    .SNOOZE_MIN(2),
    .RING_TIMEOUT_MIN(3),
    .MAX_SNOOZE(2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .min_tick       (min_tick),
    .alarm_triggered(alarm_triggered),
    .alarm_on       (alarm_on),
    .snooze         (snooze),
    .stop           (stop),
    .buzzer         (buzzer),
    .ringing        (ringing),
    .snoozed        (snoozed),
    .snooze_count   (snooze_count)
  );

  typedef struct {
    logic       trig;
    logic       on;
    logic       snz;
    logic       stp;
    logic       mt;
    logic       e_buz;
    logic       e_ring;
    logic       e_snzd;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic trig, input logic on, input logic snz, input logic stp,
                     input logic mt, input logic e_buz, input logic e_ring,
                     input logic e_snzd, input logic [2:0] e_cnt);
    vec_t v;
    v.trig = trig; v.on = on; v.snz = snz; v.stp = stp; v.mt = mt;
    v.e_buz = e_buz; v.e_ring = e_ring; v.e_snzd = e_snzd; v.e_cnt = e_cnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [2:0] act,
                       input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input logic e_buz,
                           input logic e_ring, input logic e_snzd, input logic [2:0] e_cnt);
    check({tag, ".buzzer"}, idx, {2'b0, buzzer}, {2'b0, e_buz});
    check({tag, ".ringing"}, idx, {2'b0, ringing}, {2'b0, e_ring});
    check({tag, ".snoozed"}, idx, {2'b0, snoozed}, {2'b0, e_snzd});
    check({tag, ".snooze_count"}, idx, snooze_count, e_cnt);
  endtask

  task automatic drive(input logic trig, input logic on, input logic snz, input logic stp,
                       input logic mt);
    alarm_triggered = trig; alarm_on = on; snooze = snz; stop = stp; min_tick = mt;
  endtask

  // Apply inputs for one edge, then sample 1 time unit after it.
  task automatic step(input logic trig, input logic on, input logic snz, input logic stp,
                      input logic mt);
    drive(trig, on, snz, stp, mt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // trig on snz stp mt | buz ring snzd cnt
    // Reset released with a live match: no ring until a fresh edge.
    add(1,1,0,0,0, 0,0,0,0);
    add(1,1,0,0,0, 0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0);
    // Rising edge: 4 high, 4 low, then high again.
    add(1,1,0,0,0, 1,1,0,0);
    add(1,1,0,0,0, 1,1,0,0);
    add(1,1,0,0,0, 1,1,0,0);
    add(1,1,0,0,0, 1,1,0,0);
    add(1,1,0,0,0, 0,1,0,0);
    add(1,1,0,0,0, 0,1,0,0);
    add(1,1,0,0,0, 0,1,0,0);
    add(1,1,0,0,0, 0,1,0,0);
    add(1,1,0,0,0, 1,1,0,0);
    // Three minute ticks time out into LATCHED.
    add(1,1,0,0,1, 1,1,0,0);
    add(1,1,0,0,0, 1,1,0,0);
    add(1,1,0,0,1, 1,1,0,0);
    add(1,1,0,0,1, 0,0,0,0);
    add(1,1,0,0,0, 0,0,0,0);
    add(1,1,0,0,0, 0,0,0,0);
    add(0,1,0,0,0, 0,0,0,0);
    add(1,1,0,0,0, 1,1,0,0);
    // Snooze cycle, snooze inside SNOOZED does not reload.
    add(1,1,1,0,0, 0,0,1,1);
    add(1,1,0,0,1, 0,0,1,1);
    add(1,1,0,0,0, 0,0,1,1);
    add(1,1,1,0,0, 0,0,1,1);
    add(1,1,0,0,1, 1,1,0,1);
    add(1,1,1,0,0, 0,0,1,2);
    add(1,1,0,0,1, 0,0,1,2);
    add(1,1,0,0,1, 1,1,0,2);
    // Third snooze ignored; ring_min keeps counting to timeout.
    add(1,1,1,0,0, 1,1,0,2);
    add(1,1,0,0,1, 1,1,0,2);
    add(1,1,0,0,1, 1,1,0,2);
    add(1,1,1,0,1, 0,0,0,2);
    add(0,1,0,0,0, 0,0,0,2);
    add(1,1,0,0,0, 1,1,0,0);
    // Snooze and stop together: stop wins, count unchanged.
    add(1,1,1,0,0, 0,0,1,1);
    add(1,1,0,0,1, 0,0,1,1);
    add(1,1,0,0,1, 1,1,0,1);
    add(1,1,1,1,0, 0,0,0,1);
    add(0,1,0,0,0, 0,0,0,1);
    // alarm_on dropped in SNOOZED; re-enable with live match does not ring.
    add(1,1,0,0,0, 1,1,0,0);
    add(1,1,1,0,0, 0,0,1,1);
    add(1,0,0,0,0, 0,0,0,1);
    add(1,1,0,0,0, 0,0,0,1);
    add(0,1,0,0,0, 0,0,0,1);
    add(1,1,0,0,0, 1,1,0,0);
    // Stop from SNOOZED, then pulses in IDLE are ignored.
    add(1,1,1,0,0, 0,0,1,1);
    add(1,1,0,1,0, 0,0,0,1);
    add(1,1,0,0,0, 0,0,0,1);
    add(0,1,0,0,0, 0,0,0,1);
    add(0,1,1,1,0, 0,0,0,1);
    // Snooze paired with timeout-reaching tick goes to SNOOZED.
    add(1,1,0,0,0, 1,1,0,0);
    add(1,1,0,0,1, 1,1,0,0);
    add(1,1,0,0,1, 1,1,0,0);
    add(1,1,1,0,1, 0,0,1,1);

    // Reset state while held in reset.
    drive(1, 1, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].trig, vecs[i].on, vecs[i].snz, vecs[i].stp, vecs[i].mt);
      check_all("vec", i, vecs[i].e_buz, vecs[i].e_ring, vecs[i].e_snzd, vecs[i].e_cnt);
    end

    // Asynchronous reset mid-ring with buzzer high and a snooze used.
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0);
    step(1, 1, 0, 0, 1);
    step(1, 1, 0, 0, 1);
    drive(1, 1, 0, 0, 0);
    check_all("pre_rst", 0, 1, 1, 0, 1);
    #2;
    rst = 1'b1;
    #1;
    check_all("async_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check_all("post_rst_no_edge", 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    check_all("post_rst_edge", 0, 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
